// File: rtl/ctrl_pkg.sv
// Shared widths, field positions, bundle structs and opcodes for the control pipeline.
package ctrl_pkg;

    localparam int EX_W  = 4;
    localparam int M_W   = 3;
    localparam int WB_W  = 2;
    localparam int REG_W = 5;

    // Field bit positions inside the raw ID-stage bundles.
    localparam int EX_REGDST    = 3;
    localparam int EX_ALUOP_MSB = 2;
    localparam int EX_ALUOP_LSB = 1;
    localparam int EX_ALUSRC    = 0;
    localparam int M_BRANCH     = 2;
    localparam int M_MEMREAD    = 1;
    localparam int M_MEMWRITE   = 0;
    localparam int WB_REGWRITE  = 1;
    localparam int WB_MEMTOREG  = 0;

    // Primary opcodes of the instructions this control path serves.
    localparam logic [5:0] RTYPE = 6'h00;
    localparam logic [5:0] LW    = 6'h23;
    localparam logic [5:0] SW    = 6'h2B;
    localparam logic [5:0] BEQ   = 6'h04;
    localparam logic [5:0] NOP   = 6'h00;

    typedef struct packed {
        logic       regdst;
        logic [1:0] aluop;
        logic       alusrc;
    } ex_t;

    typedef struct packed {
        logic branch;
        logic memread;
        logic memwrite;
    } m_t;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_t;

    typedef struct packed {
        ex_t              ex;
        m_t               m;
        wb_t              wb;
        logic [REG_W-1:0] rt;
    } idex_t;

    typedef struct packed {
        m_t  m;
        wb_t wb;
    } exmem_t;

    // Unpack the raw ID bundles; RegDst/MemtoReg are meaningless without RegWrite.
    function automatic idex_t capture_idex(input logic [EX_W-1:0]  ex,
                                           input logic [M_W-1:0]   m,
                                           input logic [WB_W-1:0]  wb,
                                           input logic [REG_W-1:0] rt);
        idex_t r;
        r.ex.regdst   = ex[EX_REGDST] & wb[WB_REGWRITE];
        r.ex.aluop    = ex[EX_ALUOP_MSB:EX_ALUOP_LSB];
        r.ex.alusrc   = ex[EX_ALUSRC];
        r.m.branch    = m[M_BRANCH];
        r.m.memread   = m[M_MEMREAD];
        r.m.memwrite  = m[M_MEMWRITE];
        r.wb.regwrite = wb[WB_REGWRITE];
        r.wb.memtoreg = wb[WB_MEMTOREG] & wb[WB_REGWRITE];
        r.rt          = rt;
        return r;
    endfunction

endpackage

// File: rtl/ctrl_pipe_if.sv
// Control-pipeline bus: ID-stage bundles in, staged control and hazard outputs out.
// The bubble_cnt signal exists only when CTRL_PIPE_STATS_EN is defined.
interface ctrl_pipe_if;
    import ctrl_pkg::*;

    logic [EX_W-1:0]  ex_in;
    logic [M_W-1:0]   m_in;
    logic [WB_W-1:0]  wb_in;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             branch_taken;

    logic             ex_regdst;
    logic [1:0]       ex_aluop;
    logic             ex_alusrc;
    logic [REG_W-1:0] ex_rt;
    logic             mem_branch;
    logic             mem_memread;
    logic             mem_memwrite;
    logic             wb_regwrite;
    logic             wb_memtoreg;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
`ifdef CTRL_PIPE_STATS_EN
    logic [15:0]      bubble_cnt;
`endif

    modport master (
        output ex_in, m_in, wb_in, id_rs, id_rt, branch_taken,
        input  ex_regdst, ex_aluop, ex_alusrc, ex_rt,
        input  mem_branch, mem_memread, mem_memwrite,
        input  wb_regwrite, wb_memtoreg,
        input  pc_write, ifid_write, ifid_flush
`ifdef CTRL_PIPE_STATS_EN
        , input bubble_cnt
`endif
    );

    modport slave (
        input  ex_in, m_in, wb_in, id_rs, id_rt, branch_taken,
        output ex_regdst, ex_aluop, ex_alusrc, ex_rt,
        output mem_branch, mem_memread, mem_memwrite,
        output wb_regwrite, wb_memtoreg,
        output pc_write, ifid_write, ifid_flush
`ifdef CTRL_PIPE_STATS_EN
        , output bubble_cnt
`endif
    );

endinterface

// File: rtl/ctrl_hazard.sv
// Combinational load-use stall and branch-flush decision for the control pipeline.
module ctrl_hazard
    import ctrl_pkg::*;
(
    input  logic             idex_memread_i,
    input  logic [REG_W-1:0] idex_rt_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             branch_taken_i,
    output logic             stall_o,
    output logic             flush_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o
);

    logic load_use;

    // r0 is hard-wired zero, so a load into it never creates a dependency.
    assign load_use = idex_memread_i && (idex_rt_i != '0) &&
                      ((idex_rt_i == id_rs_i) || (idex_rt_i == id_rt_i));

    // A taken branch squashes the dependent instruction, so it overrides the stall.
    assign flush_o      = branch_taken_i;
    assign stall_o      = load_use && !branch_taken_i;
    assign pc_write_o   = !stall_o;
    assign ifid_write_o = !stall_o;
    assign ifid_flush_o = flush_o;

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM and MEM/WB control registers with hazard-driven bubble insertion.
// Define CTRL_PIPE_STATS_EN to add the saturating bubble_cnt statistic.
module ctrl_pipe
    import ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    ctrl_pipe_if.slave   bus
);

    idex_t  idex_q,  idex_d;
    exmem_t exmem_q, exmem_d;
    wb_t    memwb_q, memwb_d;
    logic   stall;
    logic   flush;

    ctrl_hazard u_hazard (
        .idex_memread_i (idex_q.m.memread),
        .idex_rt_i      (idex_q.rt),
        .id_rs_i        (bus.id_rs),
        .id_rt_i        (bus.id_rt),
        .branch_taken_i (bus.branch_taken),
        .stall_o        (stall),
        .flush_o        (flush),
        .pc_write_o     (bus.pc_write),
        .ifid_write_o   (bus.ifid_write),
        .ifid_flush_o   (bus.ifid_flush)
    );

    // NOTE: every next-state value is assigned up front so no path leaves a latch.
    always_comb begin
        idex_d  = capture_idex(bus.ex_in, bus.m_in, bus.wb_in, bus.id_rt);
        exmem_d = '{m: idex_q.m, wb: idex_q.wb};
        memwb_d = exmem_q.wb;
        if (flush) begin
            idex_d  = '0;
            exmem_d = '0;
        end else if (stall) begin
            idex_d  = '0;
        end
    end

    // NOTE: non-blocking updates let all three stages shift on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign bus.ex_regdst    = idex_q.ex.regdst;
    assign bus.ex_aluop     = idex_q.ex.aluop;
    assign bus.ex_alusrc    = idex_q.ex.alusrc;
    assign bus.ex_rt        = idex_q.rt;
    assign bus.mem_branch   = exmem_q.m.branch;
    assign bus.mem_memread  = exmem_q.m.memread;
    assign bus.mem_memwrite = exmem_q.m.memwrite;
    assign bus.wb_regwrite  = memwb_q.regwrite;
    assign bus.wb_memtoreg  = memwb_q.memtoreg;

`ifdef CTRL_PIPE_STATS_EN
    logic [15:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if ((stall || flush) && (bubble_cnt_q != 16'hFFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe; stats checks compile with CTRL_PIPE_STATS_EN.
module tb_ctrl_pipe;
    import ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    ctrl_pipe_if bus ();

    ctrl_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before inputs change or outputs are read.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ex, input logic [2:0] m, input logic [1:0] wb,
                         input logic [4:0] rs, input logic [4:0] rt, input logic br);
        bus.ex_in        = ex;
        bus.m_in         = m;
        bus.wb_in        = wb;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.branch_taken = br;
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        drive(4'b0000, 3'b000, 2'b00, 5'd0, 5'd0, 1'b0);
        #3;
        check("rst_ex",      {12'd0, bus.ex_regdst, bus.ex_aluop, bus.ex_alusrc}, 16'h0);
        check("rst_mem",     {13'd0, bus.mem_branch, bus.mem_memread, bus.mem_memwrite}, 16'h0);
        check("rst_wb",      {14'd0, bus.wb_regwrite, bus.wb_memtoreg}, 16'h0);
        check("rst_hazard",  {13'd0, bus.pc_write, bus.ifid_write, bus.ifid_flush}, 16'b110);
`ifdef CTRL_PIPE_STATS_EN
        check("rst_bubbles", bus.bubble_cnt, 16'd0);
`endif
        tick();
        rst_n = 1'b1;

        // R-type pass-through with staged latency.
        drive(4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 1'b0);
        tick();
        check("rtype_aluop",  {14'd0, bus.ex_aluop}, 16'b10);
        check("rtype_ex",     {11'd0, bus.ex_regdst, bus.ex_alusrc, bus.ex_rt}, {11'd0, 2'b10, 5'd2});
        drive(4'b0000, 3'b000, 2'b00, 5'd0, 5'd0, 1'b0);
        tick();
        check("rtype_e2_wb",  {15'd0, bus.wb_regwrite}, 16'd0);
        tick();
        check("rtype_wb",     {14'd0, bus.wb_regwrite, bus.wb_memtoreg}, 16'b10);

        // Sanitise: no RegWrite clears RegDst and MemtoReg, keeps ALUOp/ALUSrc.
        drive(4'b1011, 3'b000, 2'b01, 5'd0, 5'd9, 1'b0);
        tick();
        check("san_ex",       {12'd0, bus.ex_regdst, bus.ex_aluop, bus.ex_alusrc}, 16'b0011);
        check("san_rt",       {11'd0, bus.ex_rt}, 16'd9);
        drive(4'b0000, 3'b000, 2'b00, 5'd0, 5'd0, 1'b0);
        tick();
        tick();
        check("san_wb",       {14'd0, bus.wb_regwrite, bus.wb_memtoreg}, 16'b00);

        // Load-use: LW writes r5, dependent instruction reads r5.
        drive(4'b0001, 3'b010, 2'b11, 5'd0, 5'd5, 1'b0);
        tick();
        drive(4'b1100, 3'b000, 2'b10, 5'd5, 5'd7, 1'b0);
        check("lu_stall",     {13'd0, bus.pc_write, bus.ifid_write, bus.ifid_flush}, 16'b000);
        tick();
        check("lu_bubble",    {7'd0, bus.ex_regdst, bus.ex_aluop, bus.ex_alusrc, bus.ex_rt}, 16'd0);
        check("lu_memread",   {15'd0, bus.mem_memread}, 16'd1);
        check("lu_release",   {13'd0, bus.pc_write, bus.ifid_write, bus.ifid_flush}, 16'b110);
        tick();
        check("lu_reissue",   {14'd0, bus.ex_aluop}, 16'b10);

        // Load into r0 never stalls.
        drive(4'b0001, 3'b010, 2'b11, 5'd0, 5'd0, 1'b0);
        tick();
        drive(4'b0000, 3'b000, 2'b00, 5'd0, 5'd0, 1'b0);
        check("r0_nostall",   {13'd0, bus.pc_write, bus.ifid_write, bus.ifid_flush}, 16'b110);
        tick();

        // Branch flush: R-type then SW, flush while SW sits in ID/EX.
        drive(4'b1100, 3'b000, 2'b10, 5'd1, 5'd2, 1'b0);
        tick();
        drive(4'b0001, 3'b001, 2'b00, 5'd3, 5'd4, 1'b0);
        tick();
        drive(4'b0001, 3'b010, 2'b11, 5'd6, 5'd8, 1'b1);
        check("br_flush",     {13'd0, bus.pc_write, bus.ifid_write, bus.ifid_flush}, 16'b111);
        tick();
        check("br_memwrite",  {13'd0, bus.mem_branch, bus.mem_memread, bus.mem_memwrite}, 16'd0);
        check("br_ex_zero",   {7'd0, bus.ex_regdst, bus.ex_aluop, bus.ex_alusrc, bus.ex_rt}, 16'd0);
        check("br_wb_normal", {14'd0, bus.wb_regwrite, bus.wb_memtoreg}, 16'b10);

        // Branch coincident with load-use: flush wins.
        drive(4'b0001, 3'b010, 2'b11, 5'd0, 5'd5, 1'b0);
        tick();
        drive(4'b1100, 3'b000, 2'b10, 5'd5, 5'd7, 1'b1);
        check("prio_ctrl",    {13'd0, bus.pc_write, bus.ifid_write, bus.ifid_flush}, 16'b111);
        tick();
        check("prio_memread", {15'd0, bus.mem_memread}, 16'd0);
        drive(4'b0000, 3'b000, 2'b00, 5'd0, 5'd0, 1'b0);
`ifdef CTRL_PIPE_STATS_EN
        check("bubbles_3",    bus.bubble_cnt, 16'd3);
`endif

        // Mid-stream asynchronous reset with every stage populated.
        drive(4'b1100, 3'b100, 2'b11, 5'd1, 5'd2, 1'b0);
        tick();
        tick();
        tick();
        check("pre_rst_full", {11'd0, bus.ex_regdst, bus.mem_branch, bus.wb_regwrite, 2'b00},
              {11'd0, 3'b111, 2'b00});
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ex",   {7'd0, bus.ex_regdst, bus.ex_aluop, bus.ex_alusrc, bus.ex_rt}, 16'd0);
        check("mid_rst_mem",  {13'd0, bus.mem_branch, bus.mem_memread, bus.mem_memwrite}, 16'd0);
        check("mid_rst_wb",   {14'd0, bus.wb_regwrite, bus.wb_memtoreg}, 16'd0);
        check("mid_rst_pc",   {15'd0, bus.pc_write}, 16'd1);
`ifdef CTRL_PIPE_STATS_EN
        check("mid_rst_cnt",  bus.bubble_cnt, 16'd0);
`endif
        tick();
        rst_n = 1'b1;
        drive(4'b1110, 3'b000, 2'b10, 5'd1, 5'd2, 1'b0);
        tick();
        check("post_rst_ex",  {14'd0, bus.ex_aluop}, 16'b11);
        check("post_rst_mem", {15'd0, bus.mem_branch}, 16'd0);

`ifdef CTRL_PIPE_STATS_EN
        // Saturation: 65535 flush bubbles reach FFFF, one more holds it.
        drive(4'b0000, 3'b000, 2'b00, 5'd0, 5'd0, 1'b1);
        tick();
        tick();
        check("bubbles_2",    bus.bubble_cnt, 16'd2);
        for (int i = 0; i < 65533; i++) tick();
        check("bubbles_ffff", bus.bubble_cnt, 16'hFFFF);
        tick();
        check("bubbles_hold", bus.bubble_cnt, 16'hFFFF);
        drive(4'b0000, 3'b000, 2'b00, 5'd0, 5'd0, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
- REQ-001 SHALL have port clk, input, 1, sole clock, rising edge.
- REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
- REQ-003 SHALL have port ex_in, input, 4, ID-stage EX bundle {RegDst, ALUOp[1:0], ALUSrc}.
- REQ-004 SHALL have port m_in, input, 3, ID-stage M bundle {Branch, MemRead, MemWrite}.
- REQ-005 SHALL have port wb_in, input, 2, ID-stage WB bundle {RegWrite, MemtoReg}.
- REQ-006 SHALL have ports id_rs and id_rt, input, 5 each, source registers of the instruction in ID.
- REQ-007 SHALL have port branch_taken, input, 1, branch resolved taken in MEM this cycle.
- REQ-008 SHALL have outputs ex_regdst (1), ex_aluop (2), ex_alusrc (1) and ex_rt (5), driven from the ID/EX register.
- REQ-009 SHALL have outputs mem_branch, mem_memread and mem_memwrite (1 each), driven from the EX/MEM register.
- REQ-010 SHALL have outputs wb_regwrite and wb_memtoreg (1 each), driven from the MEM/WB register.
- REQ-011 SHALL have outputs pc_write, ifid_write and ifid_flush (1 each), combinational hazard controls.
- REQ-012 SHALL have output bubble_cnt, 16, present only when CTRL_PIPE_STATS_EN is defined.

Function
- REQ-013 SHALL, on each clk edge without stall or flush: load ID/EX with {ex_in, m_in, wb_in, id_rt}; load EX/MEM with the ID/EX M and WB fields; load MEM/WB with the EX/MEM WB field.
- REQ-014 SHALL sanitise on capture into ID/EX:
  - RegDst forced to 0 when wb_in[1]=0.
  - MemtoReg forced to 0 when wb_in[1]=0.
  - ALUSrc and ALUOp kept as supplied.
- REQ-015 SHALL assert load-use stall combinationally when ID/EX MemRead=1 and ID/EX rt is nonzero and equals id_rs or id_rt.
- REQ-016 SHALL, during a stall: drive pc_write=0 and ifid_write=0; load an all-zero bubble into ID/EX, including rt; advance EX/MEM and MEM/WB normally.
- REQ-017 SHALL, when branch_taken=1: drive ifid_flush=1; load all-zero into ID/EX and EX/MEM; load MEM/WB normally.
- REQ-018 SHALL give branch_taken priority over stall in the same cycle: pc_write=1, ifid_write=1, ifid_flush=1, flush behaviour of REQ-017.
- REQ-019 SHALL drive pc_write=1, ifid_write=1 and ifid_flush=0 whenever neither stall nor branch_taken is active.
- REQ-020 SHALL have one-cycle latency per stage: ex_in appears on ex_* one edge later, on mem_* two edges later and on wb_* three edges later.

Reset
- REQ-021 SHALL clear all ID/EX, EX/MEM and MEM/WB fields to 0 immediately on rst_n=0, independent of clk.
- REQ-022 SHALL, with registers at reset value and branch_taken=0, yield pc_write=1, ifid_write=1, ifid_flush=0; bubble_cnt resets to 0.
- REQ-023 SHALL, when reset is asserted mid-operation, discard in-flight control words with no partial update on release; the first post-release edge is treated as a normal load.

Configuration
- REQ-024 SHALL, with CTRL_PIPE_STATS_EN defined, increment bubble_cnt by 1 on each edge where a stall or flush bubble is inserted, saturating at 16'hFFFF.
- REQ-025 SHALL, without CTRL_PIPE_STATS_EN, omit the bubble_cnt port and counter entirely; all other behaviour is identical.

Structure
- REQ-026 SHALL place bundle widths, field bit positions and opcode constants (RTYPE, LW, SW, BEQ, NOP) in shared package ctrl_pkg.
- REQ-027 SHALL implement the combinational stall and flush decision in one sub-module, ctrl_hazard; ctrl_pipe holds the pipeline registers and the optional counter.

Verification
- REQ-028 Reset: rst_n=0 mid-stream -> all ex_*, mem_* and wb_* outputs 0 immediately; pc_write=1.
- REQ-029 R-type pass-through: ex_in=1100, m_in=000, wb_in=10 -> ex_aluop=10 after edge 1; wb_regwrite=1, wb_memtoreg=0 after edge 3.
- REQ-030 Load-use: LW (m_in=010, id_rt=5), then id_rs=5 -> pc_write=0 and ifid_write=0 for one cycle; ID/EX becomes zero; mem_memread=1 on the next edge.
- REQ-031 rt=0 load: LW with id_rt=0, next id_rs=0 -> no stall.
- REQ-032 Branch flush: branch_taken=1 while ID/EX holds SW -> ifid_flush=1; mem_memwrite=0 on the following edge.
- REQ-033 Priority and stats: branch_taken coincident with a load-use match -> pc_write=1, ifid_flush=1; with CTRL_PIPE_STATS_EN, bubble_cnt advances 1 per bubble and holds at FFFF.
